baud_tick_gen: RTL and testbench

//  Fractional-N baud tick generator for the UART TX/RX datapath, successor to the fixed integer divider.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/baud_phase_acc.sv | 43 ++++
 rtl/baud_tick_gen.sv | 80 ++++++++
 tb/tb_baud_tick_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default oversampling and the baud increment calculation
// used both at elaboration and for software-visible divisor tables.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;

  // round(br * os * 2^acc_w / clkf); returns 0 for a zero clock so callers can reject it
  function automatic longint unsigned calc_baud_inc(
    input longint unsigned clkf,
    input longint unsigned br,
    input longint unsigned os,
    input longint unsigned acc_w
  );
    longint unsigned num;
    if (clkf == 0) return 0;
    num = (br * os) << acc_w;
    return (num + clkf / 2) / clkf;
  endfunction

endpackage

// File: rtl/baud_phase_acc.sv
// Phase accumulator for the fractional baud generator: holds acc/inc and
// reports the overflow carry of the add that the next clock edge commits.
module baud_phase_acc #(
  parameter int unsigned          ACC_W   = 16,
  parameter logic [ACC_W-1:0]     INC_DEF = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             resync,
  input  logic             cfg_load,
  input  logic [ACC_W-1:0] cfg_inc,
  output logic             carry_p0
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum_p0;

  always_comb begin
    sum_p0 = {1'b0, acc} + {1'b0, inc};
  end

  // carry is only meaningful when the add is actually committed this edge
  assign carry_p0 = en & ~resync & sum_p0[ACC_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      inc <= INC_DEF;
    end else begin
      if (resync) begin
        acc <= '0;
      end else if (en) begin
        acc <= sum_p0[ACC_W-1:0];
      end
      if (cfg_load) begin
        inc <= cfg_inc;
      end
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Fractional-N baud tick generator: oversample, mid-bit and bit-end ticks plus
// a 50% duty bit clock, derived from a phase accumulator carry.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKF       = 50_000_000,
  parameter int unsigned BR         = 115200,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned ACC_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic             cfg_load,
  input  logic             resync,
  output logic             os_tick,
  output logic             mid_tick,
  output logic             bit_tick,
  output logic             bclk
);

  localparam longint unsigned INC_CALC =
    calc_baud_inc(64'(CLKF), 64'(BR), 64'(OVERSAMPLE), 64'(ACC_W));
  localparam logic [ACC_W-1:0] INC_DEF = INC_CALC[ACC_W-1:0];

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] MID_CNT  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] LAST_CNT = OS_W'(OVERSAMPLE - 1);

  if (BR == 0 || CLKF == 0 || (OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4 ||
      INC_CALC == 0 || INC_CALC >= (64'd1 << ACC_W)) begin : g_bad_cfg
    $fatal(1, "baud_tick_gen: invalid CLKF/BR/OVERSAMPLE/ACC_W combination");
  end

  logic            carry_p0;
  logic [OS_W-1:0] os_cnt;

  baud_phase_acc #(
    .ACC_W   (ACC_W),
    .INC_DEF (INC_DEF)
  ) u_phase_acc (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .resync   (resync),
    .cfg_load (cfg_load),
    .cfg_inc  (cfg_inc),
    .carry_p0 (carry_p0)
  );

  // ---- stage p1: tick decode and bit clock, registered off the carry ----
  always_ff @(posedge clk) begin
    if (reset || resync) begin
      os_cnt   <= '0;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
      bclk     <= 1'b0;
    end else begin
      os_tick  <= carry_p0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
      if (carry_p0) begin
        if (os_cnt == LAST_CNT) begin
          os_cnt   <= '0;
          bit_tick <= 1'b1;
          bclk     <= 1'b0;
        end else begin
          os_cnt <= os_cnt + 1'b1;
        end
        if (os_cnt == MID_CNT) begin
          mid_tick <= 1'b1;
          bclk     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen with defaults ACC_W=16, OVERSAMPLE=16, 50 MHz / 115200.
module tb_baud_tick_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [15:0] cfg_inc = '0;
  logic        cfg_load = 1'b0;
  logic        resync = 1'b0;
  logic        os_tick, mid_tick, bit_tick, bclk;

  int checks = 0;
  int failures = 0;

  baud_tick_gen dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .cfg_inc  (cfg_inc),
    .cfg_load (cfg_load),
    .resync   (resync),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick),
    .bclk     (bclk)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; cfg_load = 1'b0; resync = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic load(input logic [15:0] v);
    cfg_inc = v; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  // {os,mid,bit,bclk} expected for inc=16384, m edges after the phase started at 0
  function automatic logic [3:0] pat16k(input int m);
    return {(m % 4) == 0, (m % 64) == 32, (m % 64) == 0, ((m / 32) % 2) == 1};
  endfunction

  task automatic test_reset();
    logic [3:0] got;
    reset = 1'b1; en = 1'b1;
    step(); step();
    got = {os_tick, mid_tick, bit_tick, bclk};
    checks++;
    if (got !== 4'b0000) begin
      failures++; $display("FAIL reset_outputs got=%b exp=%b", got, 4'b0000);
    end
  endtask

  task automatic test_quarter_inc();
    logic [3:0] got, exp;
    do_reset(); load(16'd16384); en = 1'b1;
    for (int n = 1; n <= 192; n++) begin
      step();
      got = {os_tick, mid_tick, bit_tick, bclk};
      exp = pat16k(n);
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL inc16384 n=%0d got=%b exp=%b", n, got, exp);
      end
    end
  endtask

  task automatic test_fractional();
    int total;
    logic exp;
    total = 0;
    do_reset(); load(16'd24576); en = 1'b1;
    for (int n = 1; n <= 8000; n++) begin
      step();
      exp = ((n % 8) == 0) || ((n % 8) == 3) || ((n % 8) == 6);
      if (os_tick) total++;
      checks++;
      if (os_tick !== exp) begin
        failures++; $display("FAIL inc24576_os n=%0d got=%b exp=%b", n, os_tick, exp);
      end
    end
    checks++;
    if (total != 3000) begin
      failures++; $display("FAIL inc24576_count got=%0d exp=3000", total);
    end
  endtask

  task automatic test_default_rate();
    int last, gap, bits, first_bit, tenth_bit;
    last = 0; bits = 0; first_bit = 0; tenth_bit = 0;
    do_reset(); en = 1'b1;
    for (int n = 1; n <= 4345; n++) begin
      step();
      if (os_tick) begin
        checks++;
        if (last == 0) begin
          if (n != 28) begin
            failures++; $display("FAIL default_first_os got=%0d exp=28", n);
          end
        end else begin
          gap = n - last;
          if (gap != 27 && gap != 28) begin
            failures++; $display("FAIL default_gap n=%0d got=%0d exp=27or28", n, gap);
          end
        end
        last = n;
      end
      if (bit_tick) begin
        bits++;
        if (bits == 1) first_bit = n;
        if (bits == 10) tenth_bit = n;
      end
    end
    checks++;
    if (first_bit != 435) begin
      failures++; $display("FAIL default_first_bit got=%0d exp=435", first_bit);
    end
    checks++;
    if (tenth_bit != 4341) begin
      failures++; $display("FAIL default_tenth_bit got=%0d exp=4341", tenth_bit);
    end
  endtask

  task automatic test_resync();
    logic [3:0] got, exp;
    do_reset(); load(16'd16384); en = 1'b1;
    for (int n = 1; n <= 23; n++) step();
    resync = 1'b1; step(); resync = 1'b0;
    got = {os_tick, mid_tick, bit_tick, bclk};
    checks++;
    if (got !== 4'b0000) begin
      failures++; $display("FAIL resync_cnt5 got=%b exp=%b", got, 4'b0000);
    end
    for (int m = 1; m <= 104; m++) begin
      step();
      got = {os_tick, mid_tick, bit_tick, bclk};
      exp = pat16k(m);
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL resync_period m=%0d got=%b exp=%b", m, got, exp);
      end
    end
    // os_cnt=10 and bclk high here; resync must drop bclk
    resync = 1'b1; step(); resync = 1'b0;
    got = {os_tick, mid_tick, bit_tick, bclk};
    checks++;
    if (got !== 4'b0000) begin
      failures++; $display("FAIL resync_bclk_high got=%b exp=%b", got, 4'b0000);
    end
    for (int m = 1; m <= 8; m++) begin
      step();
      got = {os_tick, mid_tick, bit_tick, bclk};
      exp = pat16k(m);
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL resync_restart m=%0d got=%b exp=%b", m, got, exp);
      end
    end
  endtask

  task automatic test_enable_hold();
    logic [3:0] got, exp;
    do_reset(); load(16'd16384); en = 1'b1;
    for (int n = 1; n <= 45; n++) step();
    en = 1'b0;
    for (int n = 46; n <= 55; n++) begin
      step();
      got = {os_tick, mid_tick, bit_tick, bclk};
      checks++;
      if (got !== 4'b0001) begin
        failures++; $display("FAIL en_hold n=%0d got=%b exp=%b", n, got, 4'b0001);
      end
    end
    en = 1'b1;
    for (int n = 56; n <= 110; n++) begin
      step();
      got = {os_tick, mid_tick, bit_tick, bclk};
      exp = pat16k(n - 10);
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL en_resume n=%0d got=%b exp=%b", n, got, exp);
      end
    end
  endtask

  task automatic test_reset_midrun_and_zero_inc();
    logic [3:0] got;
    int stray;
    do_reset(); load(16'd16384); en = 1'b1;
    for (int n = 1; n <= 38; n++) step();
    reset = 1'b1; step();
    got = {os_tick, mid_tick, bit_tick, bclk};
    checks++;
    if (got !== 4'b0000) begin
      failures++; $display("FAIL reset_midrun got=%b exp=%b", got, 4'b0000);
    end
    reset = 1'b0;
    for (int n = 1; n <= 28; n++) begin
      step();
      checks++;
      if (os_tick !== (n == 28)) begin
        failures++; $display("FAIL reset_inc_default n=%0d got=%b exp=%b", n, os_tick, (n == 28));
      end
    end
    do_reset(); en = 1'b1;
    load(16'd0);
    stray = 0;
    for (int n = 1; n <= 1000; n++) begin
      step();
      if (os_tick || mid_tick || bit_tick) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++; $display("FAIL zero_inc_ticks got=%0d exp=0", stray);
    end
    // acc frozen at 2416 from the load cycle; fourth add of 16384 overflows
    load(16'd16384);
    for (int n = 1; n <= 4; n++) begin
      step();
      checks++;
      if (os_tick !== (n == 4)) begin
        failures++; $display("FAIL zero_inc_frozen n=%0d got=%b exp=%b", n, os_tick, (n == 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_quarter_inc();
    test_fractional();
    test_default_rate();
    test_resync();
    test_enable_hold();
    test_reset_midrun_and_zero_inc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
